// File: rtl/apa102_out.sv
// APA102 strip transmitter: start frame, LED frames, end frame.
// Latches the pixel image on start and shifts it out on SCK/SDA.
module apa102_out #(
    parameter int LED_CNT  = 7,
    parameter int CLK_DIV  = 4,
    parameter int END_BITS = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [32*LED_CNT-1:0]  data,
    output logic                   busy,
    output logic                   done,
    output logic                   sck,
    output logic                   sda
);

    localparam int DW = 32 * LED_CNT;
    localparam int TB = 32 + DW + END_BITS;
    localparam int CW = $clog2(TB + 1);
    localparam int VW = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {
        IDLE,
        START_FRAME,
        LED_FRAME,
        END_FRAME
    } state_t;

    state_t        state, state_d;
    logic [VW-1:0] div, div_d;
    logic          hi, hi_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [DW-1:0] sh, sh_d;
    logic          sck_d, sda_d, busy_d, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            div   <= '0;
            hi    <= 1'b0;
            cnt   <= '0;
            sh    <= '0;
            sck   <= 1'b0;
            sda   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            div   <= div_d;
            hi    <= hi_d;
            cnt   <= cnt_d;
            sh    <= sh_d;
            sck   <= sck_d;
            sda   <= sda_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        div_d   = div;
        hi_d    = hi;
        cnt_d   = cnt;
        sh_d    = sh;
        sck_d   = sck;
        sda_d   = sda;
        busy_d  = busy;
        done_d  = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_d = START_FRAME;
                sh_d    = data;
                div_d   = '0;
                hi_d    = 1'b0;
                cnt_d   = '0;
                sck_d   = 1'b0;
                sda_d   = 1'b0;
                busy_d  = 1'b1;
            end
        end else if (div != VW'(CLK_DIV - 1)) begin
            div_d = div + VW'(1);
        end else begin
            div_d = '0;
            if (!hi) begin
                hi_d  = 1'b1;
                sck_d = 1'b1;
            end else begin
                // End of a bit period: choose the next bit for the low phase.
                hi_d  = 1'b0;
                sck_d = 1'b0;
                cnt_d = cnt + CW'(1);
                unique case (state)
                    START_FRAME: begin
                        sda_d = 1'b0;
                        if (cnt == CW'(31)) begin
                            state_d = LED_FRAME;
                            cnt_d   = '0;
                            sda_d   = 1'b1;
                        end
                    end
                    LED_FRAME: begin
                        sh_d = {sh[DW-2:0], 1'b0};
                        if (cnt == CW'(DW - 1)) begin
                            state_d = END_FRAME;
                            cnt_d   = '0;
                            sda_d   = 1'b1;
                        end else if (cnt_d[4:0] < 5'd3) begin
                            sda_d = 1'b1;
                        end else begin
                            sda_d = sh_d[DW-1];
                        end
                    end
                    default: begin
                        sda_d = 1'b1;
                        if (cnt == CW'(END_BITS - 1)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            sda_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apa102_out.sv
// Self-checking bench for apa102_out with LED_CNT=2, CLK_DIV=2.
// Captures SDA on SCK rises and compares with a frame-level model.
module tb_apa102_out;

    localparam int LED_CNT  = 2;
    localparam int CLK_DIV  = 2;
    localparam int END_BITS = 32;
    localparam int TB       = 32 + 32 * LED_CNT + END_BITS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] data = '0;
    logic        busy, done, sck, sda;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    apa102_out #(
        .LED_CNT (LED_CNT),
        .CLK_DIV (CLK_DIV),
        .END_BITS(END_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .data (data),
        .busy (busy),
        .done (done),
        .sck  (sck),
        .sda  (sda)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [63:0] d);
        logic [31:0] f0, f1;
        f0 = d[63:32] | 32'hE000_0000;
        f1 = d[31:0] | 32'hE000_0000;
        return {32'h0, f0, f1, 32'hFFFF_FFFF};
    endfunction

    task automatic xfer(input logic [63:0] d, input bit skip_start,
                        input bit mid, input bit chg, input bit b2b,
                        output logic [127:0] got, output int rises,
                        output int first_rise, output int rel_done,
                        output int bad);
        int n;
        logic prev;
        logic held;
        got = '0;
        rises = 0;
        first_rise = -1;
        rel_done = -1;
        bad = 0;
        held = 1'b0;
        if (!skip_start) begin
            @(negedge clk);
            data = d;
            start = 1'b1;
        end
        n = cyc;
        @(negedge clk);
        start = 1'b0;
        prev = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                rel_done = cyc - n;
                if (sck !== 1'b0 || sda !== 1'b0 || busy !== 1'b0)
                    bad++;
                if (b2b) start = 1'b1;
                break;
            end
            if (busy !== 1'b1) bad++;
            if (sck && !prev) begin
                got = {got[126:0], sda};
                held = sda;
                rises++;
                if (first_rise < 0) first_rise = cyc - n;
            end else if (sck && sda !== held) begin
                bad++;
            end
            prev = sck;
            if (chg && i == 60) data = ~d;
            if (mid && i == 100) start = 1'b1;
            if (mid && i == 101) start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic quiet(input int ncyc, output int dones, output int act);
        dones = 0;
        act = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy || sck || sda) act++;
        end
    endtask

    logic [127:0] got, got_b2b;
    logic [63:0]  d;
    int rises, fr, rd, bad, dones, act;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        act = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || sck !== 1'b0 ||
                sda !== 1'b0)
                act++;
        end
        chk("idle_outputs", 128'(act), 128'(0));

        d = {32'hFF00_00FF, 32'hE112_3456};
        xfer(d, 0, 0, 0, 0, got, rises, fr, rd, bad);
        chk("single_stream", got, model(d));
        chk("single_stream_lit", got,
            {32'h0, 32'hFF00_00FF, 32'hE112_3456, 32'hFFFF_FFFF});
        chk("single_rises", 128'(rises), 128'(TB));
        chk("single_first_rise", 128'(fr), 128'(1 + CLK_DIV));
        chk("single_done_at", 128'(rd), 128'(TB * 2 * CLK_DIV + 1));
        chk("single_protocol", 128'(bad), 128'(0));

        d = {32'h0A0B_0C0D, $urandom()};
        xfer(d, 0, 0, 0, 0, got, rises, fr, rd, bad);
        chk("header_frame0", {96'h0, got[95:64]}, 128'h0000_0000_EA0B_0C0D);
        chk("header_stream", got, model(d));

        d = {$urandom(), $urandom()};
        xfer(d, 0, 1, 1, 0, got, rises, fr, rd, bad);
        chk("hold_stream", got, model(d));
        chk("hold_done_at", 128'(rd), 128'(TB * 2 * CLK_DIV + 1));
        chk("hold_protocol", 128'(bad), 128'(0));
        quiet(600, dones, act);
        chk("hold_done_once", 128'(dones), 128'(0));
        chk("hold_idle_after", 128'(act), 128'(0));

        d = {$urandom(), $urandom()};
        xfer(d, 0, 0, 0, 1, got, rises, fr, rd, bad);
        chk("b2b_first", got, model(d));
        xfer(d, 1, 0, 0, 0, got_b2b, rises, fr, rd, bad);
        chk("b2b_identical", got_b2b, got);
        chk("b2b_first_rise", 128'(fr), 128'(1 + CLK_DIV));
        chk("b2b_done_at", 128'(rd), 128'(TB * 2 * CLK_DIV + 1));
        chk("b2b_protocol", 128'(bad), 128'(0));

        d = {$urandom(), $urandom()};
        @(negedge clk);
        data = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        chk("pre_reset_busy", 128'(busy), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_abort",
            {124'h0, sck, sda, busy, done}, 128'h0);
        quiet(600, dones, act);
        chk("reset_no_done", 128'(dones), 128'(0));
        chk("reset_stays_idle", 128'(act), 128'(0));

        d = {$urandom(), $urandom()};
        xfer(d, 0, 0, 0, 0, got, rises, fr, rd, bad);
        chk("post_reset_stream", got, model(d));
        chk("post_reset_rises", 128'(rises), 128'(TB));
        chk("post_reset_done_at", 128'(rd), 128'(TB * 2 * CLK_DIV + 1));
        chk("post_reset_protocol", 128'(bad), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
